mem_arb: RTL
============

# mem_arb

Arbiter and sequencer for a single-port unified memory shared by the CPU's instruction-fetch path (PC/IM side) and data-access path (DM side). Sits between those two requesters and the physical memory. Grants one access at a time, counts the memory's fixed latency, and returns read data with a ready pulse. Drives a stall line that freezes the PC/pipeline while any request is outstanding.

## Interface
- LAT, 2: memory latency in cycles from strobe to valid `mem_rdata`; legal range 1–15.
- AW, 16: address width.
- DW, 16: data width.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- hlt  in  1  CPU halted; blocks new fetch grants.
- if_req  in  1  fetch request (level); held until `if_rdy`.
- if_addr  in  AW  fetch address; stable while `if_req` is high.
- if_rdy  out  1  one-cycle pulse: fetch complete.
- if_data  out  DW  last fetched word (registered).
- dm_re  in  1  data read request (level).
- dm_we  in  1  data write request (level).
- dm_addr  in  AW  data address.
- dm_wdata  in  DW  write data.
- dm_rdy  out  1  one-cycle pulse: data access complete.
- dm_rdata  out  DW  last data-read word (registered).
- mem_addr  out  AW  memory address; valid in the issue cycle.
- mem_wdata  out  DW  memory write data; valid in the issue cycle.
- mem_re  out  1  one-cycle read strobe.
- mem_we  out  1  one-cycle write strobe.
- mem_rdata  in  DW  memory read data; valid exactly LAT cycles after `mem_re`.
- stall  out  1  `(if_req & ~if_rdy) | ((dm_re|dm_we) & ~dm_rdy)`, combinational.

## Operation
- States: IDLE, BUSY, RESP. Registers: state, latency counter (4 bits), owner (IF/DM), last-grant, `if_rdy`, `dm_rdy`, `if_data`, `dm_rdata`.
- IDLE: grant is evaluated combinationally. Candidates are DM (`dm_re|dm_we`) and IF (`if_req & ~hlt`). On a grant:
  - drive `mem_addr`, `mem_wdata`, and the `mem_re`/`mem_we` strobe in the same cycle;
  - load counter = LAT-1, record owner and last-grant, go to BUSY.
  - No candidate: stay in IDLE with strobes low.
- `dm_re` and `dm_we` both high: performed as a write; the read is ignored; a single `dm_rdy` is returned.
- DM write: uses `mem_we` only; `dm_rdata` is unchanged.
- IF access: always a read.
- BUSY: counter decrements each cycle. At counter==0, `mem_rdata` is valid:
  - capture it into the owner's data register (reads only);
  - set the owner's rdy register; go to RESP.
- RESP: the owner's rdy is high for exactly this cycle. No issue is allowed. Return to IDLE. Requesters drop or change their request at the end of RESP.
- `hlt` asserted while a fetch is in BUSY: the fetch completes normally.
- Reset: state IDLE, counter 0, owner IF, last-grant IF, `if_rdy`=`dm_rdy`=0, `if_data`=`dm_rdata`=0. `mem_re`/`mem_we` are forced 0 while `rst_n` is low. Reset mid-access abandons the access with no rdy pulse.

## Timing
- Grant in cycle T:
  - `mem_re`/`mem_we` high in T only;
  - `mem_rdata` sampled at the end of cycle T+LAT-1+1 (the LAT-th cycle after T);
  - rdy high in cycle T+LAT+1;
  - next grant possible in T+LAT+2.
- Throughput: one access per LAT+2 cycles.
- `stall` falls in the same cycle that rdy rises.
- No combinational path from `mem_rdata` to any output.

## Configuration
- `MEM_ARB_RR_EN` defined: when both candidates request in IDLE, grant the one not in last-grant (round-robin). First contention after reset goes to DM.
- `MEM_ARB_RR_EN` undefined: DM has fixed priority over IF. The last-grant register is unused.

## Test plan
- LAT=2. `if_req`=1, `if_addr`=0x0010 in cycle 1; memory returns 0xABCD → `mem_re` high in cycle 1 only; `if_rdy` high in cycle 4; `if_data`=0xABCD; `stall` high in cycles 1–3.
- DM write: `dm_we`=1, `dm_addr`=0x0100, `dm_wdata`=0x5A5A → `mem_we`=1 with those values for one cycle; `dm_rdy` in issue+3; `dm_rdata` unchanged (0).
- Fixed priority (macro off): `if_req` and `dm_re` rise together in cycle 1 → DM issued in cycle 1, IF issued in cycle 5, `if_rdy` in cycle 8. With the macro on, repeated contention alternates DM, IF, DM.
- `hlt`=1 with `if_req`=1 in IDLE → no strobe and `stall` stays high. Raising `hlt` during BUSY of a fetch → that fetch still returns `if_rdy`.
- Assert `rst_n`=0 in a BUSY cycle → no rdy pulse; `if_data` = 0. After release with requests still held, a fresh issue occurs in the first IDLE cycle.
- `dm_re`=`dm_we`=1 → exactly one `mem_we` strobe, no `mem_re`, one `dm_rdy`.

Source files
------------

// File: rtl/mem_arb_if.sv
// Bundle of requester-side (fetch/data) and memory-side signals for the unified-memory arbiter.
// The slave modport is the arbiter; the master modport is the CPU plus memory environment.
interface mem_arb_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          hlt;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_rdy;
    logic [DW-1:0] if_data;
    logic          dm_re;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_rdy;
    logic [DW-1:0] dm_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_re;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;
    logic          stall;

    modport slave (
        input  hlt, if_req, if_addr, dm_re, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_rdy, if_data, dm_rdy, dm_rdata, mem_addr, mem_wdata, mem_re, mem_we, stall
    );

    modport master (
        output hlt, if_req, if_addr, dm_re, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_rdy, if_data, dm_rdy, dm_rdata, mem_addr, mem_wdata, mem_re, mem_we, stall
    );
endinterface

// File: rtl/mem_arb.sv
// Single-port memory arbiter/sequencer for the fetch (IF) and data (DM) paths.
// Define MEM_ARB_RR_EN for round-robin on contention; otherwise DM has fixed priority.
module mem_arb #(
    parameter int LAT = 2,
    parameter int AW  = 16,
    parameter int DW  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    mem_arb_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

    state_t        state_r;
    logic [3:0]    cnt_r;
    logic          owner_dm_r;
    logic          wr_r;
    logic          if_rdy_r;
    logic          dm_rdy_r;
    logic [DW-1:0] if_data_r;
    logic [DW-1:0] dm_rdata_r;
`ifdef MEM_ARB_RR_EN
    logic          last_dm_r;
`endif

    logic dm_cand_s;
    logic if_cand_s;
    logic grant_dm_s;
    logic grant_if_s;
    logic issue_s;

    // Grant selection among the two candidates while idle
    always_comb begin
        dm_cand_s  = bus.dm_re | bus.dm_we;
        if_cand_s  = bus.if_req & ~bus.hlt;
`ifdef MEM_ARB_RR_EN
        grant_dm_s = dm_cand_s & (~if_cand_s | ~last_dm_r);
`else
        grant_dm_s = dm_cand_s;
`endif
        grant_if_s = if_cand_s & ~grant_dm_s;
        if (state_r == IDLE) begin
            issue_s = grant_dm_s | grant_if_s;
        end else begin
            issue_s = 1'b0;
        end
    end

    // Strobes are issued in the grant cycle and suppressed throughout reset
    assign bus.mem_addr  = grant_dm_s ? bus.dm_addr : bus.if_addr;
    assign bus.mem_wdata = bus.dm_wdata;
    assign bus.mem_re    = rst_n & issue_s & (grant_if_s | (grant_dm_s & ~bus.dm_we));
    assign bus.mem_we    = rst_n & issue_s & grant_dm_s & bus.dm_we;

    assign bus.if_rdy   = if_rdy_r;
    assign bus.dm_rdy   = dm_rdy_r;
    assign bus.if_data  = if_data_r;
    assign bus.dm_rdata = dm_rdata_r;
    assign bus.stall    = (bus.if_req & ~if_rdy_r) | ((bus.dm_re | bus.dm_we) & ~dm_rdy_r);

    // Sequencer: issue, count latency, capture read data, pulse ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            cnt_r      <= 4'd0;
            owner_dm_r <= 1'b0;
            wr_r       <= 1'b0;
            if_rdy_r   <= 1'b0;
            dm_rdy_r   <= 1'b0;
            if_data_r  <= {DW{1'b0}};
            dm_rdata_r <= {DW{1'b0}};
`ifdef MEM_ARB_RR_EN
            last_dm_r  <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if_rdy_r <= 1'b0;
                    dm_rdy_r <= 1'b0;
                    if (issue_s) begin
                        cnt_r      <= LAT_M1;
                        owner_dm_r <= grant_dm_s;
                        wr_r       <= grant_dm_s & bus.dm_we;
`ifdef MEM_ARB_RR_EN
                        last_dm_r  <= grant_dm_s;
`endif
                        state_r    <= BUSY;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                BUSY: begin
                    if (cnt_r == 4'd0) begin
                        // Read data is valid only in this cycle; writes leave the data registers alone
                        if (!wr_r && owner_dm_r) begin
                            dm_rdata_r <= bus.mem_rdata;
                        end else if (!wr_r) begin
                            if_data_r  <= bus.mem_rdata;
                        end else begin
                            dm_rdata_r <= dm_rdata_r;
                        end
                        if (owner_dm_r) begin
                            dm_rdy_r <= 1'b1;
                        end else begin
                            if_rdy_r <= 1'b1;
                        end
                        state_r <= RESP;
                    end else begin
                        cnt_r   <= cnt_r - 4'd1;
                        state_r <= BUSY;
                    end
                end
                RESP: begin
                    if_rdy_r <= 1'b0;
                    dm_rdy_r <= 1'b0;
                    state_r  <= IDLE;
                end
                default: begin
                    if_rdy_r <= 1'b0;
                    dm_rdy_r <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

endmodule
